// File: rtl/mgr_noc_locl_rx.sv
// Packet-framing receive buffer: stores NoC local-port flits and releases a packet only after its EOM commits.
// Optional statistics counters are built when MGR_NOC_LOCL_RX_STATS_EN is defined.
module mgr_noc_locl_rx #(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = 64,
  parameter int TYPE_W  = 2,
  parameter int PTYPE_W = 2,
  parameter int MGRID_W = 6
) (
  input  logic               clk,
  input  logic               reset_poweron,
  input  logic               noc__locl__dp_valid,
  input  logic [1:0]         noc__locl__dp_cntl,
  output logic               locl__noc__dp_ready,
  input  logic [TYPE_W-1:0]  noc__locl__dp_type,
  input  logic [PTYPE_W-1:0] noc__locl__dp_ptype,
  input  logic [DATA_W-1:0]  noc__locl__dp_data,
  input  logic               noc__locl__dp_pvalid,
  input  logic [MGRID_W-1:0] noc__locl__dp_mgrId,
  output logic               rx__locl__dp_valid,
  input  logic               locl__rx__dp_ready,
  output logic [1:0]         rx__locl__dp_cntl,
  output logic [TYPE_W-1:0]  rx__locl__dp_type,
  output logic [PTYPE_W-1:0] rx__locl__dp_ptype,
  output logic [DATA_W-1:0]  rx__locl__dp_data,
  output logic               rx__locl__dp_pvalid,
  output logic [MGRID_W-1:0] rx__locl__dp_mgrId,
  output logic               rx__locl__frame_err,
  output logic [15:0]        rx__locl__pkt_count,
  output logic [15:0]        rx__locl__drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = 2 + TYPE_W + PTYPE_W + DATA_W + 1 + MGRID_W;

  localparam logic [PW-1:0] DEPTH_P = DEPTH[PW-1:0];
  localparam logic [PW-1:0] ONE_P   = {{(PW-1){1'b0}}, 1'b1};

  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IN_PKT = 2'd1;
  localparam logic [1:0] ST_DROP   = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] wr_ptr, wr_nxt;
  logic [PW-1:0] commit_ptr, commit_nxt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] pkt_len, len_nxt;
  logic          err_nxt;
  logic          frame_err;

  logic [PW-1:0] occupancy;
  logic          len_full;
  logic          in_xfer;
  logic          out_xfer;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [FW-1:0] wr_word;
  logic [FW-1:0] rd_word;
  logic [FW-1:0] mem [DEPTH];

  assign occupancy = wr_ptr - rd_ptr;
  assign len_full  = (pkt_len == DEPTH_P);

  // A packet already at the length limit is dropped or rewound by whatever flit comes next,
  // so that flit is always acceptable; without this an oversize packet would stall the NoC.
  assign locl__noc__dp_ready = (occupancy < DEPTH_P) || (state == ST_DROP) ||
                               ((state == ST_IN_PKT) && len_full);

  assign in_xfer  = noc__locl__dp_valid && locl__noc__dp_ready;
  assign out_xfer = rx__locl__dp_valid && locl__rx__dp_ready;

  assign wr_word = {noc__locl__dp_cntl, noc__locl__dp_type, noc__locl__dp_ptype,
                    noc__locl__dp_data, noc__locl__dp_pvalid, noc__locl__dp_mgrId};

  always_comb begin
    state_nxt  = state;
    wr_nxt     = wr_ptr;
    commit_nxt = commit_ptr;
    len_nxt    = pkt_len;
    err_nxt    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr[AW-1:0];
    if (in_xfer) begin
      case (state)
        ST_IDLE: begin
          case (noc__locl__dp_cntl)
            CNTL_SOM_EOM: begin
              wr_en      = 1'b1;
              wr_nxt     = wr_ptr + ONE_P;
              commit_nxt = wr_ptr + ONE_P;
            end
            CNTL_SOM: begin
              wr_en     = 1'b1;
              wr_nxt    = wr_ptr + ONE_P;
              len_nxt   = ONE_P;
              state_nxt = ST_IN_PKT;
            end
            default: err_nxt = 1'b1;
          endcase
        end
        ST_IN_PKT: begin
          case (noc__locl__dp_cntl)
            CNTL_MOM: begin
              if (len_full) begin
                wr_nxt    = commit_ptr;
                err_nxt   = 1'b1;
                state_nxt = ST_DROP;
              end else begin
                wr_en   = 1'b1;
                wr_nxt  = wr_ptr + ONE_P;
                len_nxt = pkt_len + ONE_P;
              end
            end
            CNTL_EOM: begin
              if (len_full) begin
                wr_nxt  = commit_ptr;
                err_nxt = 1'b1;
              end else begin
                wr_en      = 1'b1;
                wr_nxt     = wr_ptr + ONE_P;
                commit_nxt = wr_ptr + ONE_P;
              end
              state_nxt = ST_IDLE;
            end
            CNTL_SOM: begin
              wr_en   = 1'b1;
              wr_addr = commit_ptr[AW-1:0];
              wr_nxt  = commit_ptr + ONE_P;
              len_nxt = ONE_P;
              err_nxt = 1'b1;
            end
            default: begin
              wr_en      = 1'b1;
              wr_addr    = commit_ptr[AW-1:0];
              wr_nxt     = commit_ptr + ONE_P;
              commit_nxt = commit_ptr + ONE_P;
              err_nxt    = 1'b1;
              state_nxt  = ST_IDLE;
            end
          endcase
        end
        ST_DROP: begin
          case (noc__locl__dp_cntl)
            CNTL_SOM: begin
              // Ready is forced high here, so a SOM meeting a buffer full of committed data is lost.
              if (occupancy == DEPTH_P) begin
                err_nxt = 1'b1;
              end else begin
                wr_en     = 1'b1;
                wr_nxt    = wr_ptr + ONE_P;
                len_nxt   = ONE_P;
                state_nxt = ST_IN_PKT;
              end
            end
            CNTL_EOM, CNTL_SOM_EOM: state_nxt = ST_IDLE;
            default: state_nxt = ST_DROP;
          endcase
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_len    <= '0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_nxt;
      commit_ptr <= commit_nxt;
      pkt_len    <= len_nxt;
      frame_err  <= err_nxt;
      if (out_xfer) begin
        rd_ptr <= rd_ptr + ONE_P;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign {rx__locl__dp_cntl, rx__locl__dp_type, rx__locl__dp_ptype,
          rx__locl__dp_data, rx__locl__dp_pvalid, rx__locl__dp_mgrId} = rd_word;

  assign rx__locl__dp_valid  = (rd_ptr != commit_ptr);
  assign rx__locl__frame_err = frame_err;

`ifdef MGR_NOC_LOCL_RX_STATS_EN
  logic        pkt_commit;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  // commit_ptr never advances by a full 2*DEPTH in one cycle, so any change means a commit.
  assign pkt_commit = (commit_nxt != commit_ptr);

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pkt_commit && (pkt_cnt != 16'hFFFF)) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (err_nxt && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign rx__locl__pkt_count  = pkt_cnt;
  assign rx__locl__drop_count = drop_cnt;
`else
  assign rx__locl__pkt_count  = 16'd0;
  assign rx__locl__drop_count = 16'd0;
`endif

endmodule
